// File: rtl/intr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : intr_arbiter
// Description : Multi-source interrupt controller for the CPU control FSM.
//               It catches rising edges on the IRQ lines and latches them as
//               pending bits. A mask register selects which sources may
//               request service. The lowest enabled index wins, and the
//               request is held on intr_o until take_intr_i. Further
//               requests are then blocked until do_mret_i.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_SRC        number of interrupt sources (2..16)
//   CAUSE_W      width of intr_cause_o, $clog2(N_SRC)
// Ports
//   clk_i        system clock, all logic on posedge
//   rst_ni       asynchronous active-low reset
//   irq_i        peripheral request lines, rising edge = new request
//   mask_we_i    load mask_wdata_i into the mask register
//   mask_wdata_i new mask value, 1 = source enabled
//   take_intr_i  FSM accepted the interrupt (1-cycle pulse)
//   do_mret_i    FSM executing MRET (1-cycle pulse)
//   intr_o       registered interrupt request
//   intr_cause_o index of selected source, valid while intr_o = 1
//   in_service_o handler active (taken, MRET not yet seen)
//   pending_o    latched pending bits, unmasked
//   mask_o       current mask register
// Configuration
//   INTR_ARBITER_SYNC_EN  when defined, IRQ passes through a 2-flop
//                         synchroniser (adds 2 cycles of latency)
// ============================================================================
module intr_arbiter #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = $clog2(N_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_SRC-1:0]   irq_i,
  input  logic               mask_we_i,
  input  logic [N_SRC-1:0]   mask_wdata_i,
  input  logic               take_intr_i,
  input  logic               do_mret_i,
  output logic               intr_o,
  output logic [CAUSE_W-1:0] intr_cause_o,
  output logic               in_service_o,
  output logic [N_SRC-1:0]   pending_o,
  output logic [N_SRC-1:0]   mask_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [N_SRC-1:0]   irq_s;
  logic [N_SRC-1:0]   irq_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q;
  logic               intr_q, intr_d;
  logic               in_service_q, in_service_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [N_SRC-1:0]   new_edge;
  logic [N_SRC-1:0]   clr;
  logic [N_SRC-1:0]   eligible;
  logic [CAUSE_W-1:0] sel;

`ifdef INTR_ARBITER_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  assign new_edge = irq_s & ~irq_q;
  assign eligible = pending_q & mask_q;

  // Only the source that was actually advertised to the FSM gets cleared.
  assign clr = (state_q == S_REQ && take_intr_i) ? (N_SRC'(1) << cause_q) : '0;

  // A new edge in the same cycle as the clear wins, so no request is lost.
  assign pending_d = (pending_q & ~clr) | new_edge;

  // Fixed priority: the scan runs downward, so the lowest set index wins.
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = CAUSE_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (eligible != '0) state_d = S_REQ;
      end
      S_REQ: begin
        if (take_intr_i)            state_d = S_SERVICE;
        else if (eligible == '0)    state_d = S_IDLE;
      end
      S_SERVICE: begin
        if (do_mret_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: decoded from the next state so the registered outputs
  // change on the same edge as the state.
  always_comb begin
    intr_d       = (state_d == S_REQ);
    in_service_d = (state_d == S_SERVICE);
    cause_d      = (state_d == S_REQ) ? sel : cause_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      intr_q       <= 1'b0;
      in_service_q <= 1'b0;
      cause_q      <= '0;
    end else begin
      irq_q        <= irq_s;
      pending_q    <= pending_d;
      if (mask_we_i) mask_q <= mask_wdata_i;
      intr_q       <= intr_d;
      in_service_q <= in_service_d;
      cause_q      <= cause_d;
    end
  end

  assign intr_o       = intr_q;
  assign intr_cause_o = cause_q;
  assign in_service_o = in_service_q;
  assign pending_o    = pending_q;
  assign mask_o       = mask_q;

endmodule
`default_nettype wire
